// File: rtl/sccb_reg_console_pkg.sv
// Shared types and constants for the SCCB register console.
// Holds the FSM state encoding, the default OV7670 address and the button bit map.
package sccb_console_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_CMD   = 3'd1,
        W_ADDR  = 3'd2,
        W_VAL   = 3'd3,
        R_CMD_W = 3'd4,
        R_ADDR  = 3'd5,
        R_CMD_R = 3'd6,
        R_WAIT  = 3'd7
    } state_e;

    localparam logic [6:0] OV7670_ADDR = 7'h21;

    localparam int NUM_BTN = 5;
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_U   = 2;
    localparam int BTN_D   = 3;
    localparam int BTN_C   = 4;

endpackage

// File: rtl/sccb_reg_console_if.sv
// Command and data streams between the console and the i2c master.
// The console is the master side; the i2c core is the slave side.
interface sccb_reg_console_if;

    logic [6:0] s_axis_cmd_address;
    logic       s_axis_cmd_start;
    logic       s_axis_cmd_read;
    logic       s_axis_cmd_write;
    logic       s_axis_cmd_write_multiple;
    logic       s_axis_cmd_stop;
    logic       s_axis_cmd_valid;
    logic       s_axis_cmd_ready;

    logic [7:0] s_axis_data_tdata;
    logic       s_axis_data_tvalid;
    logic       s_axis_data_tready;
    logic       s_axis_data_tlast;

    logic [7:0] m_axis_data_tdata;
    logic       m_axis_data_tvalid;
    logic       m_axis_data_tready;
    logic       m_axis_data_tlast;

    modport master (
        output s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read,
               s_axis_cmd_write, s_axis_cmd_write_multiple, s_axis_cmd_stop,
               s_axis_cmd_valid,
        input  s_axis_cmd_ready,
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        input  s_axis_data_tready,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output m_axis_data_tready
    );

    modport slave (
        input  s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read,
               s_axis_cmd_write, s_axis_cmd_write_multiple, s_axis_cmd_stop,
               s_axis_cmd_valid,
        output s_axis_cmd_ready,
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        output s_axis_data_tready,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  m_axis_data_tready
    );

endinterface

// File: rtl/sccb_reg_console_btn_release_detect.sv
// Per-bit release detector: one-cycle pulse when a button goes from pressed to released.
module btn_release_detect #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] release_o
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign release_o = prev_q & ~btn_i;

endmodule

// File: rtl/sccb_reg_console.sv
// Button console that browses OV7670 register addresses and issues SCCB writes/reads.
// state   | meaning
// IDLE    | browsing reg_addr, waiting for centre button
// W_CMD   | write command (write_multiple) offered to i2c master
// W_ADDR  | register address byte offered, more to follow
// W_VAL   | value byte offered, last of the write
// R_CMD_W | write command that sets the read pointer
// R_ADDR  | register address byte offered, last of the pointer write
// R_CMD_R | read command offered
// R_WAIT  | waiting for the returned byte
module sccb_reg_console
    import sccb_console_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = OV7670_ADDR,
    parameter int         FINE_STEP      = 1,
    parameter int         COARSE_STEP    = 16,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dbncd_l_btn,
    input  logic       dbncd_r_btn,
    input  logic       dbncd_u_btn,
    input  logic       dbncd_d_btn,
    input  logic       dbncd_c_btn,
    input  logic [8:0] switches,
    output logic [7:0] reg_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       err,
    sccb_reg_console_if.master i2c
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       FINE     = 8'(FINE_STEP);
    localparam logic [7:0]       COARSE   = 8'(COARSE_STEP);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       txn_addr_q, txn_addr_d;
    logic [7:0]       txn_val_q, txn_val_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;

    logic [NUM_BTN-1:0] btn_raw, btn_rel;

    logic       cmd_valid, cmd_read, cmd_wm;
    logic       dat_valid, dat_last, rsp_ready;
    logic [7:0] dat_data;
    logic       cmd_hs, dat_hs, rsp_hs, tmo;
    logic       unused_rsp_last;

    assign btn_raw[BTN_L] = dbncd_l_btn;
    assign btn_raw[BTN_R] = dbncd_r_btn;
    assign btn_raw[BTN_U] = dbncd_u_btn;
    assign btn_raw[BTN_D] = dbncd_d_btn;
    assign btn_raw[BTN_C] = dbncd_c_btn;

    btn_release_detect #(.N(NUM_BTN)) u_release (
        .clk       (clk),
        .reset     (reset),
        .btn_i     (btn_raw),
        .release_o (btn_rel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_hs = cmd_valid & i2c.s_axis_cmd_ready;
    assign dat_hs = dat_valid & i2c.s_axis_data_tready;
    assign rsp_hs = rsp_ready & i2c.m_axis_data_tvalid;
    assign tmo    = (state_q != IDLE) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (btn_rel[BTN_C]) state_d = switches[8] ? R_CMD_W : W_CMD;
            W_CMD:   if (cmd_hs) state_d = W_ADDR;
            W_ADDR:  if (dat_hs) state_d = W_VAL;
            W_VAL:   if (dat_hs) state_d = IDLE;
            R_CMD_W: if (cmd_hs) state_d = R_ADDR;
            R_ADDR:  if (dat_hs) state_d = R_CMD_R;
            R_CMD_R: if (cmd_hs) state_d = R_WAIT;
            R_WAIT:  if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over a handshake landing on the same cycle.
        if (tmo) state_d = IDLE;
    end

    // Down-counter reloads on every state change; hitting zero means the state overstayed.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = (state_d == IDLE) ? '0 : CNT_LOAD;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = '0;
        end
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_wm    = 1'b0;
        dat_valid = 1'b0;
        dat_data  = '0;
        dat_last  = 1'b0;
        rsp_ready = 1'b0;
        unique case (state_q)
            W_CMD, R_CMD_W: begin
                cmd_valid = 1'b1;
                cmd_wm    = 1'b1;
            end
            R_CMD_R: begin
                cmd_valid = 1'b1;
                cmd_read  = 1'b1;
            end
            W_ADDR: begin
                dat_valid = 1'b1;
                dat_data  = txn_addr_q;
            end
            W_VAL: begin
                dat_valid = 1'b1;
                dat_data  = txn_val_q;
                dat_last  = 1'b1;
            end
            R_ADDR: begin
                dat_valid = 1'b1;
                dat_data  = txn_addr_q;
                dat_last  = 1'b1;
            end
            R_WAIT:  rsp_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        reg_addr_d = reg_addr_q;
        txn_addr_d = txn_addr_q;
        txn_val_d  = txn_val_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;
        if (state_q == IDLE) begin
            if (btn_rel[BTN_C]) begin
                txn_addr_d = reg_addr_q;
                txn_val_d  = switches[7:0];
                err_d      = 1'b0;
                if (switches[8]) rd_valid_d = 1'b0;
            end else if (btn_rel[BTN_U]) begin
                reg_addr_d = reg_addr_q + COARSE;
            end else if (btn_rel[BTN_D]) begin
                reg_addr_d = reg_addr_q - COARSE;
            end else if (btn_rel[BTN_R]) begin
                reg_addr_d = reg_addr_q + FINE;
            end else if (btn_rel[BTN_L]) begin
                reg_addr_d = reg_addr_q - FINE;
            end
        end
        if (tmo) begin
            err_d = 1'b1;
        end else if (rsp_hs) begin
            rd_data_d  = i2c.m_axis_data_tdata;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_addr_q <= '0;
            txn_addr_q <= '0;
            txn_val_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            reg_addr_q <= reg_addr_d;
            txn_addr_q <= txn_addr_d;
            txn_val_q  <= txn_val_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign reg_addr = reg_addr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

    assign i2c.s_axis_cmd_address        = DEV_ADDR;
    assign i2c.s_axis_cmd_start          = cmd_valid;
    assign i2c.s_axis_cmd_stop           = cmd_valid;
    assign i2c.s_axis_cmd_read           = cmd_read;
    assign i2c.s_axis_cmd_write          = 1'b0;
    assign i2c.s_axis_cmd_write_multiple = cmd_wm;
    assign i2c.s_axis_cmd_valid          = cmd_valid;
    assign i2c.s_axis_data_tdata         = dat_data;
    assign i2c.s_axis_data_tvalid        = dat_valid;
    assign i2c.s_axis_data_tlast         = dat_last;
    assign i2c.m_axis_data_tready        = rsp_ready;

    // Reads are always single-byte, so the returned tlast carries no information.
    assign unused_rsp_last = i2c.m_axis_data_tlast;

endmodule

// File: tb/tb_sccb_reg_console.sv
// Directed bench for sccb_reg_console: address navigation table plus write/read/back-pressure/timeout/reset sequences.
module tb_sccb_reg_console;
    import sccb_console_pkg::*;

    localparam logic [4:0] M_L = 5'b00001;
    localparam logic [4:0] M_R = 5'b00010;
    localparam logic [4:0] M_U = 5'b00100;
    localparam logic [4:0] M_D = 5'b01000;
    localparam logic [4:0] M_C = 5'b10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = '0;
    logic [8:0] switches = '0;
    logic [7:0] reg_addr, rd_data;
    logic       rd_valid, busy, err;

    logic       force_rsp = 1'b0;
    logic [7:0] resp_byte = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] cmd_q[$];
    logic [8:0]  data_q[$];

    typedef struct {
        logic [4:0] btn;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    sccb_reg_console_if i2c ();

    sccb_reg_console #(
        .DEV_ADDR       (7'h21),
        .FINE_STEP      (1),
        .COARSE_STEP    (16),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dbncd_l_btn (btn[BTN_L]),
        .dbncd_r_btn (btn[BTN_R]),
        .dbncd_u_btn (btn[BTN_U]),
        .dbncd_d_btn (btn[BTN_D]),
        .dbncd_c_btn (btn[BTN_C]),
        .switches    (switches),
        .reg_addr    (reg_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .err         (err),
        .i2c         (i2c)
    );

    function automatic logic [11:0] mk_cmd(input logic rd, input logic wm);
        return {7'h21, 1'b1, rd, 1'b0, wm, 1'b1};
    endfunction

    // Handshakes are logged mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (i2c.s_axis_cmd_valid && i2c.s_axis_cmd_ready)
                cmd_q.push_back({i2c.s_axis_cmd_address, i2c.s_axis_cmd_start, i2c.s_axis_cmd_read,
                                 i2c.s_axis_cmd_write, i2c.s_axis_cmd_write_multiple, i2c.s_axis_cmd_stop});
            if (i2c.s_axis_data_tvalid && i2c.s_axis_data_tready)
                data_q.push_back({i2c.s_axis_data_tlast, i2c.s_axis_data_tdata});
        end
    end

    always @(posedge clk) begin
        #1;
        if (force_rsp) begin
            i2c.m_axis_data_tvalid = 1'b1;
            i2c.m_axis_data_tdata  = 8'hEE;
            i2c.m_axis_data_tlast  = 1'b1;
        end else if (i2c.m_axis_data_tready && !i2c.m_axis_data_tvalid) begin
            i2c.m_axis_data_tvalid = 1'b1;
            i2c.m_axis_data_tdata  = resp_byte;
            i2c.m_axis_data_tlast  = 1'b1;
        end else begin
            i2c.m_axis_data_tvalid = 1'b0;
            i2c.m_axis_data_tdata  = 8'h00;
            i2c.m_axis_data_tlast  = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        btn = m;
        tick();
        btn = '0;
        tick();
    endtask

    task automatic wait_idle(input int max, output int cyc);
        cyc = 0;
        while (busy && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_regs"}, {reg_addr, rd_data, rd_valid, busy, err}, '0);
        chk({nm, "_bus"}, {i2c.s_axis_cmd_valid, i2c.s_axis_cmd_start, i2c.s_axis_cmd_stop,
                           i2c.s_axis_cmd_read, i2c.s_axis_cmd_write, i2c.s_axis_cmd_write_multiple,
                           i2c.s_axis_data_tvalid, i2c.s_axis_data_tlast, i2c.s_axis_data_tdata,
                           i2c.m_axis_data_tready}, '0);
    endtask

    initial begin
        #100000;
        $display("watchdog expired, bench stuck");
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int  cyc;
        logic stable;

        vecs = '{
            '{M_R, 8'h01}, '{M_R, 8'h02}, '{M_R, 8'h03}, '{M_U, 8'h13},
            '{M_D, 8'h03}, '{M_D, 8'hF3}, '{M_U, 8'h03}, '{M_L, 8'h02},
            '{M_L, 8'h01}, '{M_L, 8'h00}, '{M_L, 8'hFF}, '{M_R, 8'h00},
            '{M_L | M_R, 8'h01}, '{M_U | M_D, 8'h11}, '{M_D | M_R, 8'h01},
            '{M_R | M_L | M_U, 8'h11}, '{M_L | M_R | M_U | M_D, 8'h21},
            '{M_D, 8'h11}, '{M_R, 8'h12}
        };

        i2c.s_axis_cmd_ready   = 1'b1;
        i2c.s_axis_data_tready = 1'b1;
        repeat (3) tick();
        chk_reset_state("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 19; i++) begin
            press(vecs[i].btn);
            chk($sformatf("nav[%0d]", i), reg_addr, vecs[i].exp_addr);
        end

        // Write 0x80 to register 0x12; centre outranks the simultaneous up press.
        cmd_q.delete();
        data_q.delete();
        switches = 9'h080;
        press(M_C | M_U);
        chk("wr_busy_start", busy, 1'b1);
        wait_idle(100, cyc);
        chk("wr_busy_cycles", cyc, 3);
        chk("wr_addr_kept", reg_addr, 8'h12);
        chk("wr_cmd_count", cmd_q.size(), 1);
        if (cmd_q.size() > 0) chk("wr_cmd", cmd_q[0], mk_cmd(1'b0, 1'b1));
        chk("wr_data_count", data_q.size(), 2);
        if (data_q.size() > 1) begin
            chk("wr_data0", data_q[0], 9'h012);
            chk("wr_data1", data_q[1], 9'h180);
        end

        // Read register 0x0A, slave returns 0x76.
        press(M_D);
        repeat (8) press(M_R);
        chk("rd_addr_sel", reg_addr, 8'h0A);
        cmd_q.delete();
        data_q.delete();
        switches  = 9'h100;
        resp_byte = 8'h76;
        press(M_C);
        wait_idle(100, cyc);
        chk("rd_busy_cycles", cyc, 4);
        chk("rd_cmd_count", cmd_q.size(), 2);
        if (cmd_q.size() > 1) begin
            chk("rd_cmd0", cmd_q[0], mk_cmd(1'b0, 1'b1));
            chk("rd_cmd1", cmd_q[1], mk_cmd(1'b1, 1'b0));
        end
        chk("rd_data_count", data_q.size(), 1);
        if (data_q.size() > 0) chk("rd_data0", data_q[0], 9'h10A);
        chk("rd_result", {rd_valid, busy, rd_data}, {1'b1, 1'b0, 8'h76});

        // Back-pressure on a read: nothing moves while ready is low, r presses are dropped.
        cmd_q.delete();
        data_q.delete();
        i2c.s_axis_cmd_ready   = 1'b0;
        i2c.s_axis_data_tready = 1'b0;
        resp_byte = 8'h3C;
        press(M_C);
        chk("bp_rd_valid_clr", rd_valid, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) press(M_R);
            else tick();
            stable &= i2c.s_axis_cmd_valid & i2c.s_axis_cmd_write_multiple & ~i2c.s_axis_cmd_read
                      & ~i2c.s_axis_data_tvalid & busy;
        end
        chk("bp_cmd_stable", stable, 1'b1);
        chk("bp_cmd_no_beat", cmd_q.size(), 0);
        i2c.s_axis_cmd_ready = 1'b1;
        tick();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            stable &= i2c.s_axis_data_tvalid & i2c.s_axis_data_tlast & (i2c.s_axis_data_tdata == 8'h0A)
                      & ~i2c.s_axis_cmd_valid;
        end
        chk("bp_data_stable", stable, 1'b1);
        chk("bp_one_cmd", cmd_q.size(), 1);
        chk("bp_no_data", data_q.size(), 0);
        i2c.s_axis_data_tready = 1'b1;
        wait_idle(100, cyc);
        chk("bp_busy_end", busy, 1'b0);
        chk("bp_cmd_count", cmd_q.size(), 2);
        chk("bp_data_count", data_q.size(), 1);
        chk("bp_result", {rd_valid, rd_data}, {1'b1, 8'h3C});
        chk("bp_addr_kept", reg_addr, 8'h0A);

        // Stray response beats in IDLE are not accepted.
        force_rsp = 1'b1;
        tick();
        tick();
        chk("stray_tready", i2c.m_axis_data_tready, 1'b0);
        force_rsp = 1'b0;
        tick();
        tick();
        chk("stray_ignored", {rd_valid, rd_data, busy}, {1'b1, 8'h3C, 1'b0});

        // Timeout: the command is never accepted.
        i2c.s_axis_cmd_ready = 1'b0;
        switches = 9'h055;
        press(M_C);
        wait_idle(100, cyc);
        chk("tmo_cycles", cyc, 32);
        chk("tmo_flags", {err, busy, i2c.s_axis_cmd_valid, i2c.s_axis_data_tvalid}, 4'b1000);
        chk("tmo_rd_kept", rd_data, 8'h3C);
        i2c.s_axis_cmd_ready = 1'b1;
        press(M_C);
        chk("tmo_err_clr", err, 1'b0);
        wait_idle(100, cyc);
        chk("tmo_recover_cycles", cyc, 3);

        // Reset while the value byte is on the bus.
        switches = 9'h0C3;
        press(M_C);
        tick();
        tick();
        chk("pre_rst_wval", {i2c.s_axis_data_tvalid, i2c.s_axis_data_tlast, i2c.s_axis_data_tdata},
            {1'b1, 1'b1, 8'hC3});
        i2c.s_axis_data_tready = 1'b0;
        reset = 1'b1;
        tick();
        chk_reset_state("mid_rst");
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
